// File: rtl/fir_mac_stream_if.sv
// ---------------------------------------------------------------------------
// fir_mac_stream_if
//   AXI-stream bus carrying finished FIR output samples.
//
//   Signals:
//     sm_tvalid  master -> slave  beat valid
//     sm_tdata   master -> slave  output sample (DW bits)
//     sm_tlast   master -> slave  final sample of the stream
//     sm_tready  slave  -> master downstream ready
//
//   Modports: master (the FIR MAC stage), slave (downstream consumer).
// ---------------------------------------------------------------------------
interface fir_mac_stream_if #(
    parameter int DW = 32
);
    logic          sm_tvalid;
    logic [DW-1:0] sm_tdata;
    logic          sm_tlast;
    logic          sm_tready;

    modport master (
        output sm_tvalid,
        output sm_tdata,
        output sm_tlast,
        input  sm_tready
    );

    modport slave (
        input  sm_tvalid,
        input  sm_tdata,
        input  sm_tlast,
        output sm_tready
    );
endinterface

// File: rtl/fir_mac_stream.sv
// ---------------------------------------------------------------------------
// fir_mac_stream
//   FIR multiply-accumulate stage. Accumulates Tape_Num signed products
//   (data_Do * tap_Do, truncated to pDATA_WIDTH) into one output sample,
//   buffers finished samples in a 2-entry FIFO and streams them out on an
//   AXI-stream master port. Raises stall upstream when the FIFO cannot
//   guarantee a slot for the next sample.
//
//   Ports:
//     axis_clk    in   clock
//     axis_rst_n  in   asynchronous active-low reset
//     data_Do     in   data-SRAM read word, aligned with mac_valid
//     tap_Do      in   tap-SRAM read word, aligned with mac_valid
//     mac_clr     in   start of a new sample, clears the accumulator
//     mac_valid   in   data_Do*tap_Do is a valid product this cycle
//     mac_tail    in   final product of the sample (with mac_valid)
//     mac_last    in   sample being closed is the last of the stream
//     stall       out  upstream must not issue mac_clr
//     sm          if   AXI-stream master (sm_tvalid/sm_tdata/sm_tlast/sm_tready)
//     ap_done     out  one-cycle pulse after the tlast beat is accepted
//     tap_err     out  sticky: a sample closed with a wrong product count
//     ovf_err     out  sticky: a sample was pushed into a full FIFO
// ---------------------------------------------------------------------------
module fir_mac_stream #(
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,

    input  logic [pDATA_WIDTH-1:0] data_Do,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    input  logic                   mac_clr,
    input  logic                   mac_valid,
    input  logic                   mac_tail,
    input  logic                   mac_last,
    output logic                   stall,

    fir_mac_stream_if.master       sm,

    output logic                   ap_done,
    output logic                   tap_err,
    output logic                   ovf_err
);

    // Counter is one bit wider than needed for Tape_Num and saturates, so an
    // over-long sample can never wrap back onto a matching count.
    localparam int               CNT_W = $clog2(Tape_Num + 1) + 1;
    localparam logic [CNT_W-1:0] TAPS  = CNT_W'(Tape_Num);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic                   last;
        logic [pDATA_WIDTH-1:0] data;
    } entry_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [pDATA_WIDTH-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic                   tap_err_q, tap_err_d;
    logic                   ovf_err_q, ovf_err_d;

    entry_t                 head_q,  head_d;
    entry_t                 slot1_q, slot1_d;
    logic [1:0]             count_q, count_d;

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    logic signed [2*pDATA_WIDTH-1:0] prod_full;
    logic [pDATA_WIDTH-1:0]          prod;
    logic [pDATA_WIDTH-1:0]          acc_base;
    logic [pDATA_WIDTH-1:0]          acc_sum;
    logic [CNT_W-1:0]                cnt_base;
    logic [CNT_W-1:0]                cnt_inc;

    logic   push;
    entry_t push_entry;
    logic   pop;

    assign prod_full = $signed(data_Do) * $signed(tap_Do);
    assign prod      = prod_full[pDATA_WIDTH-1:0];

    // A clear on the same edge as a product replaces the old accumulator.
    assign acc_base = mac_clr ? '0 : acc_q;
    assign cnt_base = mac_clr ? '0 : cnt_q;
    assign acc_sum  = acc_base + prod;
    assign cnt_inc  = (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);

    assign pop = sm.sm_tvalid & sm.sm_tready;

    // -----------------------------------------------------------------------
    // Control FSM: next state, accumulator and sample close
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        tap_err_d  = tap_err_q;
        push       = 1'b0;
        push_entry = '0;

        unique case (state_q)
            S_IDLE: begin
                if (mac_clr) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ACC;
                end
            end

            S_ACC: begin
                if (mac_valid) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                    if (mac_tail) begin
                        push            = 1'b1;
                        push_entry.data = acc_sum;
                        push_entry.last = mac_last;
                        if (cnt_inc != TAPS) begin
                            tap_err_d = 1'b1;
                        end
                        state_d = mac_last ? S_DRAIN : S_IDLE;
                    end
                end else if (mac_clr) begin
                    acc_d = '0;
                    cnt_d = '0;
                end
            end

            S_DRAIN: begin
                if (pop && head_q.last) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // 2-entry FIFO. The head lives in its own register so the stream outputs
    // come straight from flops; slot1 only holds the second entry.
    // -----------------------------------------------------------------------
    always_comb begin
        head_d    = head_q;
        slot1_d   = slot1_q;
        count_d   = count_q;
        ovf_err_d = ovf_err_q;

        unique case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = push_entry;
                    count_d = 2'd1;
                end
            end

            2'd1: begin
                if (push && pop) begin
                    head_d = push_entry;
                end else if (push) begin
                    slot1_d = push_entry;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end

            2'd2: begin
                if (push && pop) begin
                    head_d  = slot1_q;
                    slot1_d = push_entry;
                end else if (pop) begin
                    head_d  = slot1_q;
                    count_d = 2'd1;
                end else if (push) begin
                    // Full with no pop: drop the sample, keep contents.
                    ovf_err_d = 1'b1;
                end
            end

            default: begin
                count_d = 2'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            tap_err_q <= 1'b0;
            ovf_err_q <= 1'b0;
            head_q    <= '0;
            slot1_q   <= '0;
            count_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            tap_err_q <= tap_err_d;
            ovf_err_q <= ovf_err_d;
            head_q    <= head_d;
            slot1_q   <= slot1_d;
            count_q   <= count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Stall when a new sample could close before a slot is free: full, or one
    // entry waiting that is not leaving this cycle.
    assign stall = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);

    assign sm.sm_tvalid = (count_q != 2'd0);
    assign sm.sm_tdata  = head_q.data;
    assign sm.sm_tlast  = (count_q != 2'd0) && head_q.last;

    assign ap_done = (state_q == S_DONE);
    assign tap_err = tap_err_q;
    assign ovf_err = ovf_err_q;

endmodule

// File: tb/tb_fir_mac_stream.sv
module tb_fir_mac_stream;

    localparam int W    = 32;
    localparam int TAPS = 11;

    logic         axis_clk = 1'b0;
    logic         axis_rst_n = 1'b0;
    logic [W-1:0] data_Do = '0;
    logic [W-1:0] tap_Do = '0;
    logic         mac_clr = 1'b0;
    logic         mac_valid = 1'b0;
    logic         mac_tail = 1'b0;
    logic         mac_last = 1'b0;
    logic         stall;
    logic         ap_done;
    logic         tap_err;
    logic         ovf_err;

    fir_mac_stream_if #(.DW(W)) sm_if ();

    fir_mac_stream #(
        .pDATA_WIDTH(W),
        .Tape_Num   (TAPS)
    ) dut (
        .axis_clk  (axis_clk),
        .axis_rst_n(axis_rst_n),
        .data_Do   (data_Do),
        .tap_Do    (tap_Do),
        .mac_clr   (mac_clr),
        .mac_valid (mac_valid),
        .mac_tail  (mac_tail),
        .mac_last  (mac_last),
        .stall     (stall),
        .sm        (sm_if),
        .ap_done   (ap_done),
        .tap_err   (tap_err),
        .ovf_err   (ovf_err)
    );

    always #5 axis_clk = ~axis_clk;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W:0]   exp_q[$];          // {last, data}
    logic [W-1:0] d_arr[16];
    logic [W-1:0] t_arr[16];
    logic         done_pend = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle of upstream drive; returns at posedge+1.
    task automatic step(input logic clr, input logic v, input logic t, input logic l,
                        input logic [W-1:0] d, input logic [W-1:0] tp);
        mac_clr   = clr;
        mac_valid = v;
        mac_tail  = t;
        mac_last  = l;
        data_Do   = d;
        tap_Do    = tp;
        @(posedge axis_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_no_stall();
        for (int i = 0; i < 300 && stall; i++) idle(1);
        check("stall_timeout", 64'(stall), 64'd0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) idle(1);
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        idle(3);
    endtask

    // Products 0..n-1 from d_arr/t_arr, tail on the last one.
    task automatic send(input int n, input logic last, input logic [W-1:0] expv,
                        input bit no_wait, input bit exp_push);
        if (!no_wait) wait_no_stall();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1 && exp_push) exp_q.push_back({last, expv});
            step(1'b0, 1'b1, (i == n - 1), last, d_arr[i], t_arr[i]);
        end
        mac_clr   = 1'b0;
        mac_valid = 1'b0;
        mac_tail  = 1'b0;
        mac_last  = 1'b0;
    endtask

    task automatic fill(input logic [W-1:0] dval, input int nd, input logic [W-1:0] tval);
        for (int i = 0; i < 16; i++) begin
            d_arr[i] = (i < nd) ? dval : '0;
            t_arr[i] = tval;
        end
    endtask

    // Output monitor / scoreboard, sampled on the falling edge.
    initial begin
        logic       nxt;
        logic [W:0] head;
        forever begin
            @(negedge axis_clk);
            if (!axis_rst_n) begin
                done_pend = 1'b0;
            end else begin
                check("ap_done", 64'(ap_done), 64'(done_pend));
                nxt = 1'b0;
                if (sm_if.sm_tvalid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'(exp_q.size()), 64'd1);
                    end else begin
                        head = exp_q[0];
                        check("tdata", 64'(sm_if.sm_tdata), 64'(head[W-1:0]));
                        check("tlast", 64'(sm_if.sm_tlast), 64'(head[W]));
                        if (sm_if.sm_tready) begin
                            void'(exp_q.pop_front());
                            nxt = head[W];
                        end
                    end
                end else begin
                    check("tlast_idle", 64'(sm_if.sm_tlast), 64'd0);
                end
                done_pend = nxt;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sm_if.sm_tready = 1'b0;
        repeat (3) @(posedge axis_clk);
        #1;
        check("rst_tvalid",  64'(sm_if.sm_tvalid), 64'd0);
        check("rst_tlast",   64'(sm_if.sm_tlast), 64'd0);
        check("rst_stall",   64'(stall), 64'd0);
        check("rst_ap_done", 64'(ap_done), 64'd0);
        check("rst_tap_err", 64'(tap_err), 64'd0);
        check("rst_ovf_err", 64'(ovf_err), 64'd0);
        axis_rst_n = 1'b1;
        idle(2);

        // Single sample 1..11 -> 66
        sm_if.sm_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d_arr[i] = W'(i + 1);
            t_arr[i] = 32'd1;
        end
        send(TAPS, 1'b1, 32'd66, 1'b0, 1'b1);
        wait_drain();
        check("single_tap_err", 64'(tap_err), 64'd0);

        // Signed: -3 * 5 x 11 = -165
        fill(32'hFFFF_FFFD, 16, 32'd5);
        send(TAPS, 1'b1, 32'hFFFF_FF5B, 1'b0, 1'b1);
        wait_drain();

        // Wrap: 0x7FFFFFFF + 1 + (0x40000000*4 = 0) + 8 = 0x80000008
        fill(32'd1, 16, 32'd1);
        d_arr[0] = 32'h7FFF_FFFF;
        d_arr[2] = 32'h4000_0000;
        t_arr[2] = 32'd4;
        send(TAPS, 1'b1, 32'h8000_0008, 1'b0, 1'b1);
        wait_drain();

        // Backpressure: 10, 20, 30 with tready low
        sm_if.sm_tready = 1'b0;
        check("stall_empty", 64'(stall), 64'd0);
        fill(32'd1, 10, 32'd1);
        send(TAPS, 1'b0, 32'd10, 1'b0, 1'b1);
        check("stall_occ1", 64'(stall), 64'd1);
        fill(32'd2, 10, 32'd1);
        send(TAPS, 1'b0, 32'd20, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("stall_occ2", 64'(stall), 64'd1);
            idle(1);
        end
        sm_if.sm_tready = 1'b1;
        #1;
        check("stall_occ2_pop", 64'(stall), 64'd1);
        fill(32'd3, 10, 32'd1);
        send(TAPS, 1'b1, 32'd30, 1'b0, 1'b1);
        wait_drain();
        check("bp_ovf_err", 64'(ovf_err), 64'd0);

        // Overflow: third close while full is dropped
        sm_if.sm_tready = 1'b0;
        fill(32'd1, 10, 32'd1);
        send(TAPS, 1'b0, 32'd10, 1'b0, 1'b1);
        fill(32'd2, 10, 32'd1);
        send(TAPS, 1'b0, 32'd20, 1'b1, 1'b1);
        fill(32'd3, 10, 32'd1);
        send(TAPS, 1'b0, 32'd30, 1'b1, 1'b0);
        idle(1);
        check("ovf_err_set", 64'(ovf_err), 64'd1);
        check("ovf_tap_err", 64'(tap_err), 64'd0);
        idle(3);
        sm_if.sm_tready = 1'b1;
        wait_drain();
        fill(32'd1, 16, 32'd1);
        send(TAPS, 1'b1, 32'd11, 1'b0, 1'b1);
        wait_drain();
        check("ovf_err_sticky", 64'(ovf_err), 64'd1);

        // Count error: tail on 10th product
        fill(32'd1, 16, 32'd1);
        send(TAPS - 1, 1'b0, 32'd10, 1'b0, 1'b1);
        wait_drain();
        check("tap_err_set", 64'(tap_err), 64'd1);
        send(TAPS, 1'b1, 32'd11, 1'b0, 1'b1);
        wait_drain();
        check("tap_err_sticky", 64'(tap_err), 64'd1);

        // Reset mid-stream with one sample queued and 5 products accumulated
        sm_if.sm_tready = 1'b0;
        fill(32'd1, 16, 32'd1);
        send(TAPS, 1'b0, 32'd11, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd1);
        mac_valid  = 1'b0;
        axis_rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid",  64'(sm_if.sm_tvalid), 64'd0);
        check("mid_rst_stall",   64'(stall), 64'd0);
        check("mid_rst_tap_err", 64'(tap_err), 64'd0);
        check("mid_rst_ovf_err", 64'(ovf_err), 64'd0);
        exp_q.delete();
        @(posedge axis_clk);
        #1;
        axis_rst_n = 1'b1;
        sm_if.sm_tready = 1'b1;
        idle(1);
        send(TAPS, 1'b1, 32'd11, 1'b0, 1'b1);
        wait_drain();
        check("post_rst_tap_err", 64'(tap_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
